// File: rtl/pipeline_pkg.sv
// Shared MEM-stage definitions: access FSM encoding, MEM/WB bubble, abort read data
// and the default wait-state timeout.
package pipeline_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // Only the control half of MEM/WB is cleared on a bubble; data fields hold.
  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: request FSM, optional wait-state timeout
// (enabled by DMEM_TIMEOUT_EN) and the read-data buffer.
//
// state   | meaning
// IDLE    | no access in flight; a new access is requested combinationally
// WAIT    | request held, waiting for dmem_ack (or timeout when enabled)
// DONE    | access finished; stall released, MEM/WB loads this cycle
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mem_stall,
  output logic        bus_error,
  output logic [31:0] read_data
);

  logic [1:0] state;
  logic       access;
  logic       ack_rd;
  logic       timed_out;

  assign access    = mem_read | mem_write;
  assign dmem_req  = ((state == ST_IDLE) & access) | (state == ST_WAIT);
  assign dmem_we   = dmem_req & mem_write;
  assign mem_stall = access & (state != ST_DONE);
  assign ack_rd    = dmem_req & dmem_ack & ~dmem_we;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_error_q;

  // Abort on the last allowed WAIT cycle so exactly TIMEOUT_CYCLES WAIT cycles elapse.
  assign timed_out = (state == ST_WAIT) & ~dmem_ack & (wait_cnt == CNT_LAST);
  assign bus_error = bus_error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      bus_error_q <= timed_out;
      if ((state == ST_WAIT) && !timed_out) wait_cnt <= wait_cnt + 1'b1;
      else                                  wait_cnt <= '0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
  assign bus_error      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (access) state <= dmem_ack ? ST_DONE : ST_WAIT;
        ST_WAIT: if (dmem_ack || timed_out) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
      if (timed_out)   read_data <= ABORT_DATA;
      else if (ack_rd) read_data <= dmem_rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access via mem_access_ctrl, branch/jump resolve and
// the MEM/WB register. Wait-state timeout is built only with DMEM_TIMEOUT_EN defined.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Branch_MEM,
  input  logic        Zero_MEM,
  input  logic        jump_MEM,
  input  logic        RegWrite_in_MEM,
  input  logic        MemtoReg_in_MEM,
  input  logic [31:0] j_address_MEM,
  input  logic [31:0] address_MEM,
  input  logic [31:0] Address_in_MEM,
  input  logic [31:0] WriteData_MEM,
  input  logic [4:0]  rtd_in_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        PCSrc,
  output logic [31:0] pc_target,
  output logic        EX_Flush,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [31:0] ReadData_WB,
  output logic [31:0] ALUresult_WB,
  output logic [4:0]  rtd_WB,
  output logic        bus_error
);

  logic [31:0] read_data;
  logic        is_load;
  wb_ctrl_t    wb_ctrl;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access_ctrl (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (MemRead_MEM),
    .mem_write  (MemWrite_MEM),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .mem_stall  (mem_stall),
    .bus_error  (bus_error),
    .read_data  (read_data)
  );

  assign dmem_addr  = Address_in_MEM;
  assign dmem_wdata = WriteData_MEM;

  // A store wins when both read and write are set, so only pure reads return data.
  assign is_load = MemRead_MEM & ~MemWrite_MEM;

  assign PCSrc     = ((Branch_MEM & Zero_MEM) | jump_MEM) & ~mem_stall;
  assign pc_target = jump_MEM ? j_address_MEM : address_MEM;
  assign EX_Flush  = PCSrc;

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_ctrl      <= WB_BUBBLE;
      ReadData_WB  <= '0;
      ALUresult_WB <= '0;
      rtd_WB       <= '0;
    end else if (mem_stall) begin
      wb_ctrl <= WB_BUBBLE;
    end else begin
      // bus_error is high only in the DONE cycle of an aborted access.
      wb_ctrl.reg_write  <= RegWrite_in_MEM & ~bus_error;
      wb_ctrl.mem_to_reg <= MemtoReg_in_MEM;
      ALUresult_WB       <= Address_in_MEM;
      rtd_WB             <= rtd_in_MEM;
      if (is_load) ReadData_WB <= read_data;
    end
  end

  assign RegWrite_WB = wb_ctrl.reg_write;
  assign MemtoReg_WB = wb_ctrl.mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected MEM/WB records plus
// cycle-level checks of request, stall and branch outputs.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM, Branch_MEM, Zero_MEM, jump_MEM;
  logic        RegWrite_in_MEM, MemtoReg_in_MEM;
  logic [31:0] j_address_MEM, address_MEM, Address_in_MEM, WriteData_MEM;
  logic [4:0]  rtd_in_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall, PCSrc, EX_Flush;
  logic [31:0] pc_target;
  logic        RegWrite_WB, MemtoReg_WB;
  logic [31:0] ReadData_WB, ALUresult_WB;
  logic [4:0]  rtd_WB;
  logic        bus_error;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rtd;
  } wb_rec_t;

  wb_rec_t     sb_q[$];
  logic [31:0] last_rd;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Branch_MEM(Branch_MEM),
    .Zero_MEM(Zero_MEM), .jump_MEM(jump_MEM), .RegWrite_in_MEM(RegWrite_in_MEM),
    .MemtoReg_in_MEM(MemtoReg_in_MEM), .j_address_MEM(j_address_MEM),
    .address_MEM(address_MEM), .Address_in_MEM(Address_in_MEM),
    .WriteData_MEM(WriteData_MEM), .rtd_in_MEM(rtd_in_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .PCSrc(PCSrc), .pc_target(pc_target), .EX_Flush(EX_Flush),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .ReadData_WB(ReadData_WB),
    .ALUresult_WB(ALUresult_WB), .rtd_WB(rtd_WB), .bus_error(bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead_MEM = 0; MemWrite_MEM = 0; Branch_MEM = 0; Zero_MEM = 0; jump_MEM = 0;
    RegWrite_in_MEM = 0; MemtoReg_in_MEM = 0;
    j_address_MEM = 0; address_MEM = 0; Address_in_MEM = 0; WriteData_MEM = 0;
    rtd_in_MEM = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic push_exp(input logic rw, input logic m2r, input logic [31:0] rd,
                          input logic [31:0] alu, input logic [4:0] rtd);
    wb_rec_t e;
    e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.rtd = rtd;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    wb_rec_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk("wb_regwrite", RegWrite_WB, e.rw);
      chk("wb_memtoreg", MemtoReg_WB, e.m2r);
      chk("wb_readdata", ReadData_WB, e.rd);
      chk("wb_aluresult", ALUresult_WB, e.alu);
      chk("wb_rtd", rtd_WB, e.rtd);
    end
  endtask

  // Memory op with ack arriving wait_n cycles after the first request cycle.
  task automatic run_mem(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd_reg, input int wait_n,
                         input logic rw, input logic m2r);
    int n_stall = 0;
    int n_we = 0;
    MemRead_MEM = rd_en; MemWrite_MEM = wr_en; Address_in_MEM = addr;
    WriteData_MEM = wdata; rtd_in_MEM = rd_reg; RegWrite_in_MEM = rw; MemtoReg_in_MEM = m2r;
    if (rd_en && !wr_en) last_rd = rdata;
    push_exp(rw, m2r, last_rd, addr, rd_reg);
    for (int c = 0; c <= wait_n; c++) begin
      dmem_ack   = (c == wait_n);
      dmem_rdata = (c == wait_n) ? rdata : (32'hBAD0_0000 | 32'(c));
      @(negedge clock);
      if (mem_stall) n_stall++;
      if (dmem_we) n_we++;
      chk("req_active", dmem_req, 1);
      chk("no_bus_error", bus_error, 0);
      if (c == 0) begin
        chk("dmem_addr", dmem_addr, addr);
        chk("dmem_wdata", dmem_wdata, wdata);
      end
      @(posedge clock); #1;
      chk("wb_bubble", RegWrite_WB, 0);
    end
    dmem_ack = 0; dmem_rdata = 0;
    @(negedge clock);
    chk("done_stall", mem_stall, 0);
    chk("done_req", dmem_req, 0);
    chk("stall_cycles", n_stall, wait_n + 1);
    chk("we_cycles", n_we, wr_en ? wait_n + 1 : 0);
    @(posedge clock); #1;
    sb_pop();
    idle_inputs();
  endtask

  task automatic run_alu(input logic [31:0] alu, input logic [4:0] rd_reg, input logic rw,
                         input logic br, input logic zero, input logic jmp,
                         input logic [31:0] baddr, input logic [31:0] jaddr);
    RegWrite_in_MEM = rw; MemtoReg_in_MEM = 0; Address_in_MEM = alu; rtd_in_MEM = rd_reg;
    Branch_MEM = br; Zero_MEM = zero; jump_MEM = jmp;
    address_MEM = baddr; j_address_MEM = jaddr;
    push_exp(rw, 0, last_rd, alu, rd_reg);
    @(negedge clock);
    chk("alu_stall", mem_stall, 0);
    chk("alu_req", dmem_req, 0);
    chk("pcsrc", PCSrc, (br & zero) | jmp);
    chk("ex_flush", EX_Flush, (br & zero) | jmp);
    chk("pc_target", pc_target, jmp ? jaddr : baddr);
    @(posedge clock); #1;
    sb_pop();
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    last_rd = 0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_regwrite", RegWrite_WB, 0);
    chk("rst_memtoreg", MemtoReg_WB, 0);
    chk("rst_readdata", ReadData_WB, 0);
    chk("rst_aluresult", ALUresult_WB, 0);
    chk("rst_rtd", rtd_WB, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    @(posedge clock); #1;

    run_mem(1, 0, 32'h40, 32'h0, 32'h1234, 5'd5, 0, 1, 1);
    run_mem(0, 1, 32'h80, 32'hA5A5, 32'h0, 5'd0, 3, 0, 0);
    run_alu(32'h11, 5'd3, 1, 1, 1, 0, 32'h100, 32'h0);
    run_alu(32'h22, 5'd4, 1, 0, 0, 1, 32'h100, 32'h200);
    run_alu(32'h33, 5'd6, 1, 1, 0, 0, 32'h104, 32'h204);
    run_mem(1, 1, 32'hC0, 32'h77, 32'h5555, 5'd7, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      run_mem(1, 0, $urandom & 32'hFFFC, 32'h0, $urandom, 5'($urandom_range(1, 31)),
              $urandom_range(0, 3), 1, 1);
    end

`ifdef DMEM_TIMEOUT_EN
    MemRead_MEM = 1; Address_in_MEM = 32'h600; rtd_in_MEM = 5'd4;
    RegWrite_in_MEM = 1; MemtoReg_in_MEM = 1; dmem_ack = 0;
    last_rd = 32'hDEADBEEF;
    push_exp(0, 1, last_rd, 32'h600, 5'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("to_stall", mem_stall, 1);
      chk("to_bus_error_lo", bus_error, 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("to_bus_error_hi", bus_error, 1);
    chk("to_done_stall", mem_stall, 0);
    @(posedge clock); #1;
    sb_pop();
    idle_inputs();
    @(negedge clock);
    chk("to_bus_error_pulse", bus_error, 0);
    @(posedge clock); #1;
`else
    run_mem(1, 0, 32'h500, 32'h0, 32'hCAFE, 5'd3, 12, 1, 1);
`endif

    // Reset while waiting, with ack arriving on the reset edge.
    MemRead_MEM = 1; Address_in_MEM = 32'h300; rtd_in_MEM = 5'd9;
    RegWrite_in_MEM = 1; MemtoReg_in_MEM = 1; dmem_ack = 0;
    @(negedge clock);
    chk("rw_req_idle", dmem_req, 1);
    @(posedge clock); #1;
    reset = 1; dmem_ack = 1; dmem_rdata = 32'h7777;
    @(negedge clock);
    chk("rw_req_wait", dmem_req, 1);
    @(posedge clock); #1;
    reset = 0;
    idle_inputs();
    @(negedge clock);
    chk("rw_req", dmem_req, 0);
    chk("rw_stall", mem_stall, 0);
    chk("rw_regwrite", RegWrite_WB, 0);
    chk("rw_memtoreg", MemtoReg_WB, 0);
    chk("rw_readdata", ReadData_WB, 0);
    chk("rw_aluresult", ALUresult_WB, 0);
    chk("rw_rtd", rtd_WB, 0);
    @(posedge clock); #1;
    last_rd = 0;

    run_alu(32'h44, 5'd8, 1, 0, 0, 0, 32'h0, 32'h0);
    run_mem(1, 0, 32'h48, 32'h0, 32'h9999, 5'd10, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
